// File: rtl/sub_pkg.sv
// Shared definitions for the serial minuend-reconstruction block: FSM state
// encoding and the default operand width.
package sub_pkg;

    // Default width of the original signed operands.
    localparam int W = 4;

    // Controller states: waiting for start, adding one bit per clock, and the
    // single result-valid cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : sub_pkg

// File: rtl/fa_1.sv
// One-bit full adder. It is the only arithmetic element of the serial datapath.
module fa_1 (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and carry of three input bits.
    always_comb begin
        sum  = x ^ y ^ cin;
        cout = (x & y) | (x & cin) | (y & cin);
    end

endmodule : fa_1

// File: rtl/sub_restore_serial.sv
// Recovers the minuend a = s + b from a difference word s and a subtrahend b.
// The add runs bit-serially, LSB first, through a single full adder. It takes
// W+2 clocks. The result registers change only on the final SHIFT edge, so
// a_full, a and ovf stay stable while the next reconstruction runs.
//
// Handshake: start is a request. It is accepted only on a rising edge where
// the FSM is in IDLE, and s/b are captured on that same edge. busy is high
// for the W+2 SHIFT cycles. done is a one-cycle pulse in the following cycle,
// and in that cycle the new result is already on a_full/a/ovf. start is
// ignored while busy or done is high.
module sub_restore_serial
    import sub_pkg::*;
#(
    parameter int W = sub_pkg::W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [W:0]   s,
    input  logic signed [W-1:0] b,
    output logic                busy,
    output logic                done,
    output logic signed [W+1:0] a_full,
    output logic signed [W-1:0] a,
    output logic                ovf
);

    // Width of the sign-extended operands and of the exact sum.
    localparam int N     = W + 2;
    localparam int CNT_W = $clog2(W + 3);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q;
    logic [N-1:0]       op_s_q;
    logic [N-1:0]       op_b_q;
    // Sum bits collected so far. The newest bit enters at the top, and after
    // N-1 shifts the first (LSB) sum bit has reached position 0.
    logic [N-2:0]       part_q;
    logic [N-1:0]       a_full_q;
    logic               ovf_q;

    logic               fa_sum;
    logic               fa_cout;
    logic               accept;
    logic               last_bit;
    logic [N-1:0]       result_d;
    logic               ovf_d;

    // Add the current LSBs of both operands plus the stored carry.
    fa_1 u_fa (
        .x    (op_s_q[0]),
        .y    (op_b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Decode the accept and final-bit conditions and assemble the finished
    // word. The result overflows the W-bit range unless its top three bits
    // are all equal.
    always_comb begin
        accept   = (state_q == IDLE) && start;
        last_bit = (state_q == SHIFT) && (cnt_q == CNT_W'(N - 1));
        result_d = {fa_sum, part_q};
        ovf_d    = ~((&result_d[N-1:W-1]) | ~(|result_d[N-1:W-1]));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. DONE always returns to IDLE after one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Status outputs decoded directly from the state.
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    // Serial datapath. Load the operands on accept, then shift one bit per
    // SHIFT edge. The result registers are written only on the last bit, and
    // the final carry-out is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            op_s_q   <= '0;
            op_b_q   <= '0;
            part_q   <= '0;
            a_full_q <= '0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            op_s_q   <= {s[W], s};
            op_b_q   <= {{2{b[W-1]}}, b};
            part_q   <= '0;
        end else if (state_q == SHIFT) begin
            cnt_q    <= cnt_q + CNT_W'(1);
            carry_q  <= fa_cout;
            op_s_q   <= op_s_q >> 1;
            op_b_q   <= op_b_q >> 1;
            part_q   <= {fa_sum, part_q[N-2:1]};
            if (last_bit) begin
                a_full_q <= result_d;
                ovf_q    <= ovf_d;
            end
        end
    end

    // Result outputs come from the held registers.
    always_comb begin
        a_full = a_full_q;
        a      = a_full_q[W-1:0];
        ovf    = ovf_q;
    end

endmodule : sub_restore_serial

// File: tb/tb_sub_restore_serial.sv
// Bench for sub_restore_serial. A cycle-level model predicts, from the start
// requests alone, when each request is accepted, when busy and done are high,
// and what result (s + b) is presented. A compare process checks the DUT
// against that model on every falling edge. Directed scenarios also pin
// literal results.
module tb_sub_restore_serial;

    localparam int W = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic signed [W:0]   s;
    logic signed [W-1:0] b;
    logic                busy;
    logic                done;
    logic signed [W+1:0] a_full;
    logic signed [W-1:0] a;
    logic                ovf;

    int checks = 0;
    int errors = 0;

    sub_restore_serial #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .s      (s),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .a_full (a_full),
        .a      (a),
        .ovf    (ovf)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A request seen on an edge is accepted if no operation is active, or if
    // at least W+4 edges have passed since the last accept. That gap covers
    // W+2 SHIFT edges, the edge into IDLE and the first edge in IDLE. The sum
    // for each accepted request appears W+2 edges after its accept.
    int                  cyc = 0;
    bit                  acc_valid = 1'b0;
    int                  acc = 0;
    logic signed [W+1:0] held = '0;
    logic signed [W+1:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_valid = 1'b0;
            held      = '0;
            exp_q.delete();
        end else begin
            cyc = cyc + 1;
            if (acc_valid && cyc == acc + W + 2 && exp_q.size() > 0)
                held = exp_q.pop_front();
            if (start && (!acc_valid || cyc >= acc + W + 4)) begin
                acc_valid = 1'b1;
                acc       = cyc;
                exp_q.push_back((W+2)'(int'(s) + int'(b)));
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        bit                  e_busy;
        bit                  e_done;
        logic signed [W-1:0] e_a;
        e_busy = acc_valid && cyc >= acc && cyc <= acc + W + 1;
        e_done = acc_valid && cyc == acc + W + 2;
        e_a    = held[W-1:0];
        chk("busy", int'(busy), int'(e_busy));
        chk("done", int'(done), int'(e_done));
        chk("a_full", int'(a_full), int'(held));
        chk("a", int'(a), int'(e_a));
        chk("ovf", int'(ovf), int'(int'(held) < -(2**(W-1)) || int'(held) > 2**(W-1) - 1));
    end

    // ---------------- driver ----------------
    // Issue one request and wait for done, with a bounded wait. With noisy=1,
    // start, s and b are scrambled while the operation runs, including on the
    // DONE edge.
    task automatic op(input int sv, input int bv, input bit noisy,
                      input bit has_lit, input int lit_full, input int lit_ovf);
        int                  lat;
        bit                  seen;
        logic signed [W-1:0] ea;
        @(negedge clk);
        s     = (W+1)'(sv);
        b     = W'(bv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (noisy) begin
            s = (W+1)'($urandom);
            b = W'($urandom);
        end
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < 4 * W + 20; k++) begin
            if (done) begin
                seen = 1'b1;
                lat  = k;
                break;
            end
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                s     = (W+1)'($urandom);
                b     = W'($urandom);
            end
            @(negedge clk);
        end
        chk("done_seen", int'(seen), 1);
        if (seen) chk("latency", lat, W + 2);
        if (seen && has_lit) begin
            ea = W'(lit_full);
            chk("a_full_lit", int'(a_full), lit_full);
            chk("a_lit", int'(a), int'(ea));
            chk("ovf_lit", int'(ovf), lit_ovf);
        end
        if (noisy) begin
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        s     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_a_full", int'(a_full), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;

        // Directed results with literal expectations.
        op(1, -1, 1'b0, 1'b1, 0, 0);
        op(-15, 7, 1'b0, 1'b1, -8, 0);
        op(15, 7, 1'b0, 1'b1, 22, 1);
        op(-16, -8, 1'b0, 1'b1, -24, 1);

        // Noisy start, s and b during SHIFT and DONE. The original result
        // must survive.
        op(5, -3, 1'b1, 1'b1, 2, 0);
        op(-9, 2, 1'b1, 1'b1, -7, 0);

        // Start held high across a whole operation: the second request is
        // accepted on the first IDLE edge, using the operands present then.
        @(negedge clk);
        s     = 5'sd5;
        b     = 4'sd2;
        start = 1'b1;
        @(negedge clk);
        s = -5'sd3;
        b = 4'sd4;
        repeat (W + 4) @(negedge clk);
        start = 1'b0;
        repeat (W + 4) @(negedge clk);
        chk("held_start_a_full", int'(a_full), 1);

        // Reset in the third SHIFT cycle aborts the operation.
        @(negedge clk);
        s     = 5'sd7;
        b     = 4'sd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_a_full", int'(a_full), 0);
        chk("abort_ovf", int'(ovf), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op(3, -2, 1'b0, 1'b1, 1, 0);

        // Exhaustive sweep of all operand pairs.
        for (int si = -(2**W); si < 2**W; si++)
            for (int bi = -(2**(W-1)); bi < 2**(W-1); bi++)
                op(si, bi, 1'b0, 1'b0, 0, 0);

        // Random operations with mid-operation noise.
        for (int r = 0; r < 40; r++)
            op($urandom_range(0, 2**(W+1) - 1) - 2**W,
               $urandom_range(0, 2**W - 1) - 2**(W-1), 1'b1, 1'b0, 0, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sub_restore_serial

// File: doc/sub_restore_serial.md
SUB_RESTORE_SERIAL -- requirements
Module: sub_restore_serial

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the width of the original signed operands.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a reconstruction.
REQ-005 The block SHALL have port s, input, W+1 bits, signed: the difference word (minuend minus subtrahend).
REQ-006 The block SHALL have port b, input, W bits, signed: the subtrahend.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a reconstruction is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking a new valid result.
REQ-009 The block SHALL have port a_full, output, W+2 bits, signed: the exact recovered minuend, s + b.
REQ-010 The block SHALL have port a, output, W bits, signed: a_full truncated to W bits.
REQ-011 The block SHALL have port ovf, output, 1 bit: high when a_full lies outside [-2^(W-1), 2^(W-1)-1].

Function
REQ-012 The block SHALL recover the minuend bit-serially, LSB first, one bit per clock, over W+2 cycles.
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL load s and b, each sign-extended to W+2 bits, clear the carry flop and the bit counter, and enter SHIFT.
REQ-015 In SHIFT, each edge SHALL add one operand bit pair plus carry, shift the sum bit into the result register MSB-first, register the carry-out and increment the counter.
REQ-016 After the (W+2)th SHIFT edge, the FSM SHALL enter DONE; a_full, a and ovf SHALL update on that same edge.
REQ-017 DONE SHALL last exactly one cycle, with done=1, then return to IDLE unconditionally.
REQ-018 busy SHALL be 1 exactly while the state is SHIFT.
REQ-019 Latency: done SHALL be high in the cycle following the (W+2)th edge after the start-accept edge; for W=4, done is high 6 cycles after start is sampled.
REQ-020 start SHALL be ignored in SHIFT and in DONE; a start held high SHALL be accepted at the first IDLE edge.
REQ-021 s and b SHALL be sampled only at the accept edge; later input changes SHALL NOT affect the result in progress.
REQ-022 No overflow of W+2 bits is possible (range -(3·2^(W-1)) .. 3·2^(W-1)-2); the final carry-out SHALL be discarded.
REQ-023 a_full, a and ovf SHALL hold their values until the next DONE, and SHALL NOT change during SHIFT.

Reset
REQ-024 rst_n=0 SHALL asynchronously force: state IDLE; busy=0, done=0, a_full=0, a=0, ovf=0; counter, carry and shift registers cleared.
REQ-025 A reset during SHIFT SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Structure
REQ-026 A shared package sub_pkg SHALL hold the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default operand width constant W=4.
REQ-027 The 1-bit full adder SHALL be a separate sub-module fa_1 (ports x, y, cin, sum, cout), instantiated once.
REQ-028 The counter width SHALL be $clog2(W+3).

Verification
REQ-029 Scenario: s=1, b=-1 (4'b1111), start for one cycle -> busy high for 6 cycles, done after 6 cycles, a_full=0, a=0, ovf=0.
REQ-030 Scenario: s=-15 (5'b10001), b=7 -> a_full=-8 (6'b111000), a=4'b1000, ovf=0.
REQ-031 Scenario: s=15, b=7 -> a_full=22 (6'b010110), a=4'b0110, ovf=1; and s=-16, b=-8 -> a_full=-24 (6'b101000), ovf=1.
REQ-032 Scenario: start re-pulsed during SHIFT and during DONE, with s/b changed mid-operation -> exactly one done pulse carrying the original result; a held start is accepted on the next IDLE edge.
REQ-033 Scenario: rst_n pulled low on the 3rd SHIFT cycle -> all outputs 0 immediately, no done; after release, s=3, b=-2 -> a_full=1.
REQ-034 Scenario: exhaustive sweep of all s in [-16,15] and b in [-8,7] against the software model a_full = s + b and ovf = (a_full<-8 || a_full>7), with zero mismatches.
